// File: rtl/fp_mul_result_checker.sv
// fp_mul_result_checker
// Streams {a, b, expected} vectors into a combinational multiplier under test,
// waits a fixed settle time, compares the result bit-exactly and keeps
// pass/fail statistics plus a record of the first mismatch.
module fp_mul_result_checker #(
    parameter int unsigned N_TESTS = 100000,
    parameter int unsigned SETTLE  = 1,
    parameter int unsigned CNT_W   = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vec_valid,
    input  logic [95:0]      vec_data,
    output logic             vec_ready,
    output logic [31:0]      a_operand,
    output logic [31:0]      b_operand,
    input  logic [31:0]      result,
    output logic [CNT_W-1:0] test_n,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             fail_pulse,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [31:0]      first_fail_exp,
    output logic [31:0]      first_fail_got,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SETTLE,
        S_COMPARE,
        S_DONE
    } state_t;

    // Settle counter is preloaded with SETTLE-1 so SETTLE stays exactly SETTLE cycles.
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [CNT_W-1:0] LAST_TEST   = CNT_W'(N_TESTS);

    state_t           state_q;
    logic [3:0]       settle_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [31:0]      exp_q;
    logic [CNT_W-1:0] test_n_q;
    logic [CNT_W-1:0] pass_q;
    logic [CNT_W-1:0] fail_q;
    logic [CNT_W-1:0] ff_idx_q;
    logic [31:0]      ff_exp_q;
    logic [31:0]      ff_got_q;
    logic             fail_pulse_q;
    logic             done_q;

    logic [CNT_W-1:0] test_n_d;
    logic             match_d;
    logic             last_d;

    // Compare-stage helpers: next test number, exact 32-bit match, run-complete flag.
    always_comb begin
        test_n_d = test_n_q + 1'b1;
        match_d  = (result == exp_q);
        last_d   = (test_n_d == LAST_TEST);
    end

    // Sequencing FSM; all outputs are registers updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            settle_q     <= '0;
            a_q          <= '0;
            b_q          <= '0;
            exp_q        <= '0;
            test_n_q     <= '0;
            pass_q       <= '0;
            fail_q       <= '0;
            ff_idx_q     <= '0;
            ff_exp_q     <= '0;
            ff_got_q     <= '0;
            fail_pulse_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            fail_pulse_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        test_n_q <= '0;
                        pass_q   <= '0;
                        fail_q   <= '0;
                        ff_idx_q <= '0;
                        ff_exp_q <= '0;
                        ff_got_q <= '0;
                        done_q   <= 1'b0;
                        state_q  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // vec_ready is high exactly in this state, so vec_valid alone marks a transfer.
                    if (vec_valid) begin
                        a_q      <= vec_data[95:64];
                        b_q      <= vec_data[63:32];
                        exp_q    <= vec_data[31:0];
                        settle_q <= SETTLE_LAST;
                        state_q  <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_q == '0) begin
                        state_q <= S_COMPARE;
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end
                S_COMPARE: begin
                    test_n_q <= test_n_d;
                    if (match_d) begin
                        pass_q <= pass_q + 1'b1;
                    end else begin
                        fail_q       <= fail_q + 1'b1;
                        fail_pulse_q <= 1'b1;
                        if (fail_q == '0) begin
                            ff_idx_q <= test_n_d;
                            ff_exp_q <= exp_q;
                            ff_got_q <= result;
                        end
                    end
                    if (last_d) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign vec_ready      = (state_q == S_FETCH);
    assign a_operand      = a_q;
    assign b_operand      = b_q;
    assign test_n         = test_n_q;
    assign pass_cnt       = pass_q;
    assign fail_cnt       = fail_q;
    assign fail_pulse     = fail_pulse_q;
    assign first_fail_idx = ff_idx_q;
    assign first_fail_exp = ff_exp_q;
    assign first_fail_got = ff_got_q;
    assign done           = done_q;

endmodule

// File: tb/tb_fp_mul_result_checker.sv
// Bench for fp_mul_result_checker: a simple FP multiplier stand-in drives
// result, a transaction-level model predicts every output each cycle, and the
// directed scenarios pin the model with hand-computed values.
module tb_fp_mul_result_checker;

    localparam int unsigned N  = 4;
    localparam int unsigned ST = 1;
    localparam int unsigned CW = 17;
    localparam logic [31:0] ONE = 32'h3F80_0000;
    localparam logic [31:0] TWO = 32'h4000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          vec_valid = 1'b0;
    logic [95:0]   vec_data = '0;
    logic          vec_ready;
    logic [31:0]   a_operand;
    logic [31:0]   b_operand;
    logic [31:0]   result;
    logic [CW-1:0] test_n;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] fail_cnt;
    logic          fail_pulse;
    logic [CW-1:0] first_fail_idx;
    logic [31:0]   first_fail_exp;
    logic [31:0]   first_fail_got;
    logic          done;

    fp_mul_result_checker #(.N_TESTS(N), .SETTLE(ST), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .vec_valid(vec_valid), .vec_data(vec_data), .vec_ready(vec_ready),
        .a_operand(a_operand), .b_operand(b_operand), .result(result),
        .test_n(test_n), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .fail_pulse(fail_pulse), .first_fail_idx(first_fail_idx),
        .first_fail_exp(first_fail_exp), .first_fail_got(first_fail_got),
        .done(done)
    );

    always #5 clk = ~clk;

    // Normal-range single-precision multiply, truncating; stands in for the unit under test.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic [22:0] m;
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        if (p[47]) begin
            m = p[46:24];
            e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd126;
        end else begin
            m = p[45:23];
            e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    always_comb result = fmul(a_operand, b_operand);

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        int          due;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } pend_t;

    pend_t       pq[$];
    pend_t       cur;
    int          cyc = 0;
    int          start_due = -1;
    int          op_due = -1;
    int          start_cyc = 0;
    int          done_lat = 0;
    int          pulses_seen = 0;
    logic        done_prev = 1'b0;
    logic        run_m = 1'b0;
    logic        done_m = 1'b0;
    logic        pulse_m = 1'b0;
    logic        ready_m = 1'b0;
    int          tn_m = 0;
    int          pc_m = 0;
    int          fc_m = 0;
    int          ffi_m = 0;
    logic [31:0] ffe_m = '0;
    logic [31:0] ffg_m = '0;
    logic [31:0] a_m = '0;
    logic [31:0] b_m = '0;
    logic [31:0] na = '0;
    logic [31:0] nb = '0;
    logic [31:0] got_m;

    // Compare process: outputs seen at each falling edge reflect the preceding rising edge.
    always @(negedge clk) begin
        cyc++;
        pulse_m = 1'b0;
        if (!rst_n) begin
            pq.delete();
            start_due = -1; op_due = -1;
            run_m = 1'b0; done_m = 1'b0;
            tn_m = 0; pc_m = 0; fc_m = 0; ffi_m = 0;
            ffe_m = '0; ffg_m = '0; a_m = '0; b_m = '0;
        end else begin
            if (start_due == cyc) begin
                tn_m = 0; pc_m = 0; fc_m = 0; ffi_m = 0;
                ffe_m = '0; ffg_m = '0;
                run_m = 1'b1; done_m = 1'b0;
                start_cyc = cyc;
            end
            if (op_due == cyc) begin
                a_m = na; b_m = nb;
            end
            if (pq.size() > 0 && pq[0].due == cyc) begin
                cur = pq.pop_front();
                got_m = fmul(cur.a, cur.b);
                tn_m++;
                if (got_m == cur.e) begin
                    pc_m++;
                end else begin
                    if (fc_m == 0) begin
                        ffi_m = tn_m; ffe_m = cur.e; ffg_m = got_m;
                    end
                    fc_m++;
                    pulse_m = 1'b1;
                end
                if (tn_m == int'(N)) done_m = 1'b1;
            end
        end
        ready_m = run_m && !done_m && (pq.size() == 0);

        check("test_n",         32'(test_n),         32'(tn_m));
        check("pass_cnt",       32'(pass_cnt),       32'(pc_m));
        check("fail_cnt",       32'(fail_cnt),       32'(fc_m));
        check("first_fail_idx", 32'(first_fail_idx), 32'(ffi_m));
        check("first_fail_exp", first_fail_exp,      ffe_m);
        check("first_fail_got", first_fail_got,      ffg_m);
        check("a_operand",      a_operand,           a_m);
        check("b_operand",      b_operand,           b_m);
        check("done",           32'(done),           32'(done_m));
        check("vec_ready",      32'(vec_ready),      32'(ready_m));
        check("fail_pulse",     32'(fail_pulse),     32'(pulse_m));

        if (fail_pulse) pulses_seen++;
        if (done && !done_prev) done_lat = cyc - start_cyc;
        done_prev = done;

        if (rst_n) begin
            if (start && (!run_m || done_m)) start_due = cyc + 1;
            if (ready_m && vec_valid) begin
                pq.push_back('{due: cyc + int'(ST) + 2, a: vec_data[95:64],
                               b: vec_data[63:32], e: vec_data[31:0]});
                op_due = cyc + 1;
                na = vec_data[95:64];
                nb = vec_data[63:32];
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits (bounded) for FETCH, idles gap cycles, then presents one vector.
    task automatic feed(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e, input int gap);
        int k;
        k = 0;
        if (gap > 0) vec_valid = 1'b0;
        while (!vec_ready && k < 100) begin
            tick();
            k++;
        end
        if (!vec_ready) begin
            check("ready_timeout", 32'(vec_ready), 32'd1);
            return;
        end
        repeat (gap) tick();
        vec_data  = {a, b, e};
        vec_valid = 1'b1;
        tick();
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 200) begin
            tick();
            k++;
        end
        check("done_timeout", 32'(done), 32'd1);
        vec_valid = 1'b0;
        tick();
    endtask

    logic [31:0] ve[4];
    int          vg[4];

    task automatic run_std();
        do_start();
        for (int i = 0; i < 4; i++) feed(ONE, TWO, ve[i], vg[i]);
        wait_done();
    endtask

    task automatic set_std();
        for (int i = 0; i < 4; i++) begin
            ve[i] = TWO;
            vg[i] = 0;
        end
    endtask

    function automatic logic [31:0] rnd_fp();
        logic [31:0] x;
        x = $urandom;
        x[30:23] = 8'($urandom_range(100, 154));
        return x;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          p0;
        logic [31:0] ra, rb, re;
        logic        aborted;

        repeat (3) tick();
        check("rst_test_n", 32'(test_n), 32'd0);
        check("rst_ready",  32'(vec_ready), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // All four vectors match: 1.0 * 2.0 = 2.0.
        set_std();
        run_std();
        check("A_pass", 32'(pass_cnt), 32'd4);
        check("A_fail", 32'(fail_cnt), 32'd0);
        check("A_idx",  32'(first_fail_idx), 32'd0);
        check("A_lat",  32'(done_lat), 32'd12);

        // Vector 2 expectation corrupted.
        set_std();
        ve[1] = 32'h4000_0001;
        p0 = pulses_seen;
        run_std();
        check("B_fail",   32'(fail_cnt), 32'd1);
        check("B_idx",    32'(first_fail_idx), 32'd2);
        check("B_exp",    first_fail_exp, 32'h4000_0001);
        check("B_got",    first_fail_got, 32'h4000_0000);
        check("B_pulses", 32'(pulses_seen - p0), 32'd1);

        // Vectors 2 and 3 corrupted.
        set_std();
        ve[1] = 32'h4000_0001;
        ve[2] = 32'h4000_0001;
        p0 = pulses_seen;
        run_std();
        check("C_fail",   32'(fail_cnt), 32'd2);
        check("C_idx",    32'(first_fail_idx), 32'd2);
        check("C_pulses", 32'(pulses_seen - p0), 32'd2);

        // Five idle cycles in FETCH before vector 3.
        set_std();
        vg[2] = 5;
        run_std();
        check("D_pass", 32'(pass_cnt), 32'd4);
        check("D_test", 32'(test_n), 32'd4);
        check("D_lat",  32'(done_lat), 32'd17);

        // Reset during SETTLE of vector 3, then a clean rerun.
        set_std();
        do_start();
        for (int i = 0; i < 3; i++) feed(ONE, TWO, TWO, 0);
        rst_n = 1'b0;
        #1;
        check("E_async_test_n", 32'(test_n), 32'd0);
        check("E_async_a",      a_operand, 32'd0);
        check("E_async_ready",  32'(vec_ready), 32'd0);
        vec_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        run_std();
        check("E_test", 32'(test_n), 32'd4);
        check("E_pass", 32'(pass_cnt), 32'd4);

        // Start during COMPARE is ignored; start in DONE clears and reruns.
        do_start();
        feed(ONE, TWO, TWO, 0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 4; i++) feed(ONE, TWO, TWO, 0);
        wait_done();
        check("F_test", 32'(test_n), 32'd4);
        do_start();
        check("F_clr_test", 32'(test_n), 32'd0);
        check("F_clr_done", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) feed(ONE, TWO, 32'h4000_0001, 0);
        wait_done();
        check("F_fail", 32'(fail_cnt), 32'd4);

        // Randomized runs with gaps, corruptions, stray starts and resets.
        for (int r = 0; r < 30; r++) begin
            aborted = 1'b0;
            do_start();
            for (int i = 0; i < int'(N); i++) begin
                ra = rnd_fp();
                rb = rnd_fp();
                re = fmul(ra, rb);
                if ($urandom_range(0, 3) == 0) re = re ^ (32'h1 << $urandom_range(0, 31));
                feed(ra, rb, re, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0);
                if (i == 1 && (r % 5) == 2) begin
                    start = 1'b1;
                    tick();
                    start = 1'b0;
                end
                if (i == 2 && (r % 7) == 4) begin
                    rst_n = 1'b0;
                    vec_valid = 1'b0;
                    tick();
                    rst_n = 1'b1;
                    tick();
                    aborted = 1'b1;
                    break;
                end
            end
            if (!aborted) wait_done();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fp_mul_result_checker.md
FP_MUL_RESULT_CHECKER -- requirements
Module: fp_mul_result_checker

Interface
REQ-001 SHALL have parameter N_TESTS, default 100000, number of vectors to check before completion.
REQ-002 SHALL have parameter SETTLE, default 1, number of wait cycles between operand drive and result sample (range 1..15).
REQ-003 SHALL have parameter CNT_W, default 17, width of all counters and indices.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a run from IDLE.
REQ-007 SHALL have port vec_valid  input  1  vec_data holds a valid vector.
REQ-008 SHALL have port vec_data  input  96  {a_operand[95:64], b_operand[63:32], expected[31:0]}.
REQ-009 SHALL have port vec_ready  output  1  checker accepts vec_data this cycle.
REQ-010 SHALL have port a_operand  output  32  registered operand A to the multiplier.
REQ-011 SHALL have port b_operand  output  32  registered operand B to the multiplier.
REQ-012 SHALL have port result  input  32  multiplier result, combinational from a_operand/b_operand.
REQ-013 SHALL have port test_n  output  CNT_W  vectors compared so far.
REQ-014 SHALL have port pass_cnt  output  CNT_W  vectors with result == expected.
REQ-015 SHALL have port fail_cnt  output  CNT_W  vectors with result != expected.
REQ-016 SHALL have port fail_pulse  output  1  one-cycle pulse on each mismatch.
REQ-017 SHALL have port first_fail_idx  output  CNT_W  1-based test number of first mismatch, 0 if none.
REQ-018 SHALL have port first_fail_exp  output  32  expected value of first mismatch.
REQ-019 SHALL have port first_fail_got  output  32  obtained value of first mismatch.
REQ-020 SHALL have port done  output  1  high from completion until next start or reset.

Function
REQ-021 SHALL implement FSM states IDLE, FETCH, SETTLE, COMPARE, DONE.
REQ-022 SHALL go IDLE->FETCH on start; start ignored in FETCH, SETTLE, COMPARE.
REQ-023 SHALL, on start, clear test_n, pass_cnt, fail_cnt, first_fail_* and done in the same edge.
REQ-024 SHALL assert vec_ready only in FETCH; transfer occurs when vec_valid && vec_ready.
REQ-025 SHALL, on transfer, load a_operand, b_operand, and an internal expected register, then enter SETTLE.
REQ-026 SHALL remain in FETCH with all registers held while vec_valid is low.
REQ-027 SHALL stay in SETTLE exactly SETTLE cycles, then enter COMPARE.
REQ-028 SHALL, in COMPARE, sample result in one cycle, increment test_n, and increment exactly one of pass_cnt/fail_cnt.
REQ-029 SHALL compare all 32 bits exactly (no NaN or signed-zero equivalence).
REQ-030 SHALL, on mismatch, pulse fail_pulse for the COMPARE-exit cycle and capture first_fail_* only when fail_cnt was 0.
REQ-031 SHALL go COMPARE->DONE when the incremented test_n equals N_TESTS, else COMPARE->FETCH.
REQ-032 SHALL, per vector with vec_valid held high, take SETTLE+2 cycles (FETCH, SETTLE x SETTLE, COMPARE).
REQ-033 SHALL hold a_operand/b_operand stable from FETCH transfer through COMPARE.
REQ-034 SHALL in DONE assert done, hold all counters, and return to FETCH (with clearing per REQ-023) on start.
REQ-035 SHALL keep pass_cnt + fail_cnt == test_n at every clock edge.

Reset
REQ-036 SHALL, on rst_n low, immediately force state IDLE and all outputs to 0 (a_operand, b_operand, counters, first_fail_*, done, vec_ready, fail_pulse).
REQ-037 SHALL, on reset mid-run, discard the in-flight vector without counting it.
REQ-038 SHALL leave IDLE only after rst_n is deasserted and start is seen.

Verification
REQ-039 N_TESTS=4, SETTLE=1, multiplier correct, vectors 3F800000*40000000=40000000 x4 -> pass_cnt=4, fail_cnt=0, done at cycle 12 after start, first_fail_idx=0.
REQ-040 Vector 2 expected corrupted to 40000001 (got 40000000) -> fail_cnt=1, first_fail_idx=2, first_fail_exp=40000001, first_fail_got=40000000, one fail_pulse.
REQ-041 Mismatches on vectors 2 and 3 -> first_fail_idx stays 2, fail_cnt=2, two fail_pulses.
REQ-042 vec_valid low 5 cycles before vector 3 -> vec_ready held high, no counter change, totals as REQ-039.
REQ-043 rst_n low during SETTLE of vector 3 -> all outputs 0 asynchronously, restart by start yields test_n=4 at done.
REQ-044 start asserted in DONE -> counters cleared, new run completes; start in COMPARE -> ignored.
